// File: rtl/dma_line_scheduler.sv
// Cuts each frame line into PCIe MWr TLPs capped at the payload size and split at 4 KB boundaries.
// Latency: one cycle from a granted request to the first data beat; one NEXT cycle between TLPs.
// Backpressure: tlp_dst_rdy_n stalls beats; cfg_bus_mast_en low holds off new requests only.
module dma_line_scheduler #(
  parameter int MAX_PCIE_PAYLOAD_SIZE = 128,
  parameter int LINE_CNT_WIDTH        = 12
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset_n,
  input  logic                      frame_start,
  input  logic [63:0]               fstart,
  input  logic [23:0]               line_size,
  input  logic [23:0]               line_pitch,
  input  logic [LINE_CNT_WIDTH-1:0] lines_per_frame,
  input  logic [2:0]                cfg_setmaxpld,
  input  logic                      cfg_bus_mast_en,
  input  logic                      line_ready,
  output logic                      tlp_req_to_send,
  input  logic                      tlp_grant,
  output logic [6:0]                tlp_fmt_type,
  output logic [9:0]                tlp_length_in_dw,
  output logic [63:0]               tlp_address,
  output logic [7:0]                tlp_ldwbe_fdwbe,
  output logic                      tlp_src_rdy_n,
  input  logic                      tlp_dst_rdy_n,
  output logic                      buf_rd_en,
  output logic                      line_done,
  output logic                      frame_done,
  output logic                      busy
);

  typedef enum logic [2:0] {IDLE, WAIT_LINE, REQ, DATA, NEXT} state_t;

  localparam logic [12:0] MAX_PLD = 13'(MAX_PCIE_PAYLOAD_SIZE);
  localparam logic [LINE_CNT_WIDTH-1:0] LINE_ONE = LINE_CNT_WIDTH'(1);

  state_t                    state, state_nxt;
  logic [63:0]               line_base, cur_addr;
  logic [23:0]               line_size_r, pitch_r, line_rem;
  logic [LINE_CNT_WIDTH-1:0] lines_left;
  logic [12:0]               pld_r, dec_pld, eff_pld, to_4k, next_size, tlp_size;
  logic [23:0]               size_w;
  logic [9:0]                beat_cnt, tlp_beats;
  logic                      empty_r, cfg_empty, last_beat, end_of_line, last_line, load_hdr;

  // Decode the configured max payload and clamp it to the build-time cap
  always_comb begin
    dec_pld = 13'd128;
    case (cfg_setmaxpld)
      3'd1:    dec_pld = 13'd256;
      3'd2:    dec_pld = 13'd512;
      default: dec_pld = 13'd128;
    endcase
    eff_pld = (dec_pld < MAX_PLD) ? dec_pld : MAX_PLD;
  end

  // Next TLP size: smallest of payload cap, bytes left in the line, and bytes to the next 4 KB page
  always_comb begin
    to_4k  = 13'h1000 - {1'b0, cur_addr[11:0]};
    size_w = {11'd0, pld_r};
    if (line_rem < size_w) size_w = line_rem;
    if ({11'd0, to_4k} < size_w) size_w = {11'd0, to_4k};
    next_size = size_w[12:0];
  end

  assign cfg_empty   = (line_size[23:3] == '0) || (lines_per_frame == '0);
  assign tlp_beats   = tlp_size[12:3];
  assign last_beat   = !tlp_dst_rdy_n && (beat_cnt == tlp_beats - 10'd1);
  assign end_of_line = (line_rem == '0);
  assign last_line   = (lines_left == LINE_ONE);

  // State register
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt       = state;
    tlp_req_to_send = 1'b0;
    tlp_src_rdy_n   = 1'b1;
    buf_rd_en       = 1'b0;
    line_done       = 1'b0;
    frame_done      = 1'b0;
    load_hdr        = 1'b0;
    busy            = (state != IDLE);
    case (state)
      IDLE: begin
        // An empty frame goes straight to NEXT so frame_done fires on the following cycle
        if (frame_start) state_nxt = cfg_empty ? NEXT : WAIT_LINE;
      end
      WAIT_LINE: begin
        if (line_ready && cfg_bus_mast_en) begin
          state_nxt = REQ;
          load_hdr  = 1'b1;
        end
      end
      REQ: begin
        tlp_req_to_send = 1'b1;
        if (tlp_grant) state_nxt = DATA;
      end
      DATA: begin
        tlp_src_rdy_n = 1'b0;
        buf_rd_en     = !tlp_dst_rdy_n;
        if (last_beat) state_nxt = NEXT;
      end
      NEXT: begin
        if (empty_r) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else if (end_of_line) begin
          line_done  = 1'b1;
          frame_done = last_line;
          state_nxt  = last_line ? IDLE : WAIT_LINE;
        end else if (cfg_bus_mast_en) begin
          state_nxt = REQ;
          load_hdr  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame configuration, address walk, beat counting and header registers
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      line_base        <= '0;
      cur_addr         <= '0;
      line_size_r      <= '0;
      pitch_r          <= '0;
      line_rem         <= '0;
      lines_left       <= '0;
      pld_r            <= '0;
      empty_r          <= 1'b0;
      beat_cnt         <= '0;
      tlp_size         <= '0;
      tlp_address      <= '0;
      tlp_fmt_type     <= '0;
      tlp_length_in_dw <= '0;
      tlp_ldwbe_fdwbe  <= '0;
    end else begin
      if (state == IDLE && frame_start) begin
        line_base   <= {fstart[63:3], 3'b000};
        cur_addr    <= {fstart[63:3], 3'b000};
        line_size_r <= {line_size[23:3], 3'b000};
        line_rem    <= {line_size[23:3], 3'b000};
        pitch_r     <= {line_pitch[23:3], 3'b000};
        lines_left  <= lines_per_frame;
        pld_r       <= eff_pld;
        empty_r     <= cfg_empty;
      end
      if (load_hdr) begin
        tlp_size         <= next_size;
        tlp_address      <= cur_addr;
        tlp_fmt_type     <= (cur_addr[63:32] != '0) ? 7'h60 : 7'h40;
        tlp_length_in_dw <= next_size[11:2];
        tlp_ldwbe_fdwbe  <= 8'hFF;
      end
      if (state == DATA && !tlp_dst_rdy_n) begin
        if (last_beat) begin
          beat_cnt <= '0;
          cur_addr <= cur_addr + {51'd0, tlp_size};
          line_rem <= line_rem - {11'd0, tlp_size};
        end else begin
          beat_cnt <= beat_cnt + 10'd1;
        end
      end
      if (state == NEXT && !empty_r && end_of_line) begin
        lines_left <= lines_left - LINE_ONE;
        line_base  <= line_base + {40'd0, pitch_r};
        cur_addr   <= line_base + {40'd0, pitch_r};
        line_rem   <= line_size_r;
      end
    end
  end

endmodule

// File: doc/dma_line_scheduler.md
DMA_LINE_SCHEDULER -- requirements
Module: dma_line_scheduler

Interface
REQ-001 SHALL have parameter MAX_PCIE_PAYLOAD_SIZE, default 128, meaning the upper cap on TLP payload in bytes (128/256/512).
REQ-002 SHALL have parameter LINE_CNT_WIDTH, default 12, meaning the width of the line counter and of lines_per_frame.
REQ-003 SHALL have one clock, axi_clk (input, 1), with all logic on its rising edge.
REQ-004 SHALL have reset axi_reset_n (input, 1), asynchronous and active-low.
REQ-005 SHALL have frame_start (input, 1): a single-cycle pulse that arms one frame.
REQ-006 SHALL have fstart (input, 64): the frame base byte address; bits [2:0] are ignored and treated as 0.
REQ-007 SHALL have line_size (input, 24): bytes per line; bits [2:0] are ignored.
REQ-008 SHALL have line_pitch (input, 24): the byte distance between line bases; bits [2:0] are ignored.
REQ-009 SHALL have lines_per_frame (input, LINE_CNT_WIDTH): the number of lines per frame.
REQ-010 SHALL have cfg_setmaxpld (input, 3): PCIe max payload, where 0=128, 1=256, 2=512 and other values are treated as 128.
REQ-011 SHALL have cfg_bus_mast_en (input, 1): when low, no new TLP is requested.
REQ-012 SHALL have line_ready (input, 1): a full line is available in the upstream buffer.
REQ-013 SHALL have tlp_req_to_send (output, 1) and tlp_grant (input, 1) as the arbitration handshake.
REQ-014 SHALL have tlp_fmt_type (output, 7), tlp_length_in_dw (output, 10), tlp_address (output, 64) and tlp_ldwbe_fdwbe (output, 8) as the TLP header fields.
REQ-015 SHALL have tlp_src_rdy_n (output, 1) and tlp_dst_rdy_n (input, 1) as the 64-bit data-beat handshake, both active-low.
REQ-016 SHALL have buf_rd_en (output, 1): pops one 64-bit beat from the upstream buffer.
REQ-017 SHALL have line_done (output, 1) and frame_done (output, 1) as single-cycle pulses, and busy (output, 1).

Function
REQ-018 SHALL latch fstart, line_size, line_pitch, lines_per_frame and the effective payload on frame_start in IDLE.
- Effective payload = min(MAX_PCIE_PAYLOAD_SIZE, decoded cfg_setmaxpld).
REQ-019 SHALL ignore frame_start while busy=1.
REQ-020 SHALL implement the states IDLE, WAIT_LINE, REQ, DATA and NEXT:
- IDLE -> WAIT_LINE on frame_start.
- WAIT_LINE -> REQ when line_ready=1 and cfg_bus_mast_en=1.
- REQ -> DATA on tlp_grant=1.
- DATA -> NEXT after the last beat.
- NEXT -> REQ if the line has remaining bytes and cfg_bus_mast_en=1; otherwise NEXT waits while cfg_bus_mast_en=0.
- NEXT -> WAIT_LINE at end of line if lines remain.
- NEXT -> IDLE at end of frame.
REQ-021 SHALL compute the TLP size as min(effective payload, remaining line bytes, 4096 - tlp_address[11:0]), so that no TLP crosses a 4 KB boundary.
- tlp_length_in_dw = size/4.
REQ-022 SHALL drive tlp_fmt_type = 7'h60 (MWr, 4DW header) when tlp_address[63:32] != 0, else 7'h40 (3DW header).
REQ-023 SHALL drive tlp_ldwbe_fdwbe = 8'hFF for every TLP.
REQ-024 SHALL hold tlp_req_to_send = 1 from REQ entry until the cycle tlp_grant is sampled 1, and deassert it in DATA.
REQ-025 SHALL keep all header outputs stable from REQ entry until DATA exit.
REQ-026 SHALL drive tlp_src_rdy_n = 0 throughout DATA.
- A beat is consumed in each cycle with tlp_dst_rdy_n=0; buf_rd_en = 1 in exactly those cycles.
- Beats per TLP = length_in_dw/2.
REQ-027 SHALL advance the address by the TLP size after each TLP (64-bit modulo wrap).
- At end of line: line base += line_pitch, address = new line base.
REQ-028 SHALL pulse line_done for one cycle in NEXT when the last TLP of a line completes.
- It SHALL also pulse frame_done in the same cycle when that line is the last line of the frame.
REQ-029 SHALL treat line_size=0 or lines_per_frame=0 as an empty frame: frame_done pulses one cycle after frame_start, no TLP is issued, and the block returns to IDLE.
REQ-030 SHALL let cfg_bus_mast_en falling during DATA finish the current TLP, with no new REQ while it stays low.
REQ-031 SHALL drive busy = 1 in every state except IDLE.

Reset
REQ-032 SHALL, on axi_reset_n=0 in any state, return immediately to IDLE with these output values:
- tlp_req_to_send = 0, tlp_src_rdy_n = 1, buf_rd_en = 0.
- line_done = 0, frame_done = 0, busy = 0.
- header outputs = 0.
- Latched configuration cleared.
REQ-033 SHALL not resume the interrupted frame after reset release; a new frame_start is required.

Verification
REQ-034 Nominal: fstart=0xA0000000, line_size=0x1000, pitch=0x1000, lines=2, maxpld=0 -> 64 TLPs, each 32 DW/16 beats with fmt 7'h40, addresses 0xA0000000..0xA0001F80, 2 line_done, 1 frame_done.
REQ-035 4 KB split: fstart=0xA0000FC0, line_size=0x100, maxpld=2, MAX=512 -> TLP lengths 16, 48 DW at 0xA0000FC0, 0xA0001000.
REQ-036 64-bit address and backpressure: fstart=0x1_00000000, tlp_dst_rdy_n toggling 1-of-2 -> fmt 7'h60, exactly 16 buf_rd_en per 128-byte TLP, headers stable.
REQ-037 Bus master disabled mid-line: cfg_bus_mast_en=0 during DATA -> current TLP completes, req stays 0 until re-enabled, then resumes at the correct next address.
REQ-038 Reset during DATA beat 5 -> all outputs take reset values asynchronously, busy=0, and no activity until the next frame_start.
REQ-039 Empty frame: lines_per_frame=0 -> frame_done one cycle after frame_start, and tlp_req_to_send never asserted.
